// File: rtl/aes_encipher_iter_pkg.sv
// Shared AES encipher/decipher definitions: round counts, key-length codes,
// control FSM encodings and GF(2^8) multiply helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package aes_encipher_iter_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int AES256_ROUNDS = 14;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  typedef enum logic [2:0] {
    CTRL_IDLE = 3'd0,
    CTRL_INIT = 3'd1,
    CTRL_SBOX = 3'd2,
    CTRL_MIX  = 3'd3,
    CTRL_DONE = 3'd4
  } ctrl_state_e;

  // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_encipher_iter_if.sv
// Bus between the encipher round logic and its surroundings (control/API
// layer driving next/keylen/block, key memory answering round_key).
// Latency: n/a. Backpressure: single ready level; next is ignored while ready=0.
//   master: system side (drives next, keylen, block, round_key)
//   slave : encipher datapath (drives round_key_addr, new_block, ready)
interface aes_encipher_iter_if;

  logic         next;
  logic         keylen;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, block, round_key,
    input  round_key_addr, new_block, ready
  );

  modport slave (
    input  next, keylen, block, round_key,
    output round_key_addr, new_block, ready
  );

endinterface

// File: rtl/aes_encipher_iter_sbox.sv
// Forward AES S-box, one byte in, one byte out.
// Latency: combinational.
// Backpressure: none.
//   in_i  : byte to substitute
//   out_o : SubBytes(in_i)
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_encipher_iter.sv
// Iterative AES-128/256 encipher: one 32-bit word per cycle through 4 shared
// S-boxes, round keys fetched by address from the key memory.
// Latency: accept to ready=1 is 52 cycles (AES-128) / 72 cycles (AES-256).
// Backpressure: one operation in flight; next is only honoured in IDLE.
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : next/keylen/block in, round_key_addr/round_key key fetch,
//                new_block/ready out
module aes_encipher_iter
  import aes_encipher_iter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  aes_encipher_iter_if.slave  bus
);

  localparam logic [3:0] LAST_128 = 4'(AES128_ROUNDS);
  localparam logic [3:0] LAST_256 = 4'(AES256_ROUNDS);

  ctrl_state_e  state_q, state_d;
  logic [31:0]  w_q [0:3];
  logic [31:0]  w_d [0:3];
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [3:0]   rk_addr;

  logic [127:0] cur_blk;
  logic [31:0]  sel_word;
  logic [31:0]  sub_word;
  logic [3:0]   last_round;
  logic         is_last;

  // Row r of the state is byte r of every word; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [31:0] c0, c1, c2, c3;
    c0 = b[127:96]; c1 = b[95:64]; c2 = b[63:32]; c3 = b[31:0];
    return {c0[31:24], c1[23:16], c2[15:8], c3[7:0],
            c1[31:24], c2[23:16], c3[15:8], c0[7:0],
            c2[31:24], c3[23:16], c0[15:8], c1[7:0],
            c3[31:24], c0[23:16], c1[15:8], c2[7:0]};
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    b0 = c[31:24]; b1 = c[23:16]; b2 = c[15:8]; b3 = c[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    return {mix_word(b[127:96]), mix_word(b[95:64]),
            mix_word(b[63:32]),  mix_word(b[31:0])};
  endfunction

  assign cur_blk    = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign last_round = (keylen_q == AES_256_BIT_KEY) ? LAST_256 : LAST_128;
  assign is_last    = (round_ctr_q == last_round);

  // One word per cycle shares the four S-boxes.
  assign sel_word = w_q[sword_ctr_q];

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sel_word[8*i +: 8]),
      .out_o (sub_word[8*i +: 8])
    );
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE: if (bus.next) state_d = CTRL_INIT;
      CTRL_INIT: state_d = CTRL_SBOX;
      CTRL_SBOX: if (sword_ctr_q == 2'd3) state_d = CTRL_MIX;
      CTRL_MIX:  state_d = is_last ? CTRL_DONE : CTRL_SBOX;
      CTRL_DONE: state_d = CTRL_IDLE;
      default:   state_d = CTRL_IDLE;
    endcase
  end

  // The key address is combinational so the key memory answers in-cycle.
  always_comb begin
    rk_addr = 4'd0;
    case (state_q)
      CTRL_SBOX, CTRL_MIX: rk_addr = round_ctr_q;
      default:             rk_addr = 4'd0;
    endcase
  end

  assign bus.round_key_addr = rk_addr;
  assign bus.ready          = ready_q;
  assign bus.new_block      = cur_blk;

  // ------------------------------------------------------------ datapath
  always_comb begin
    logic [127:0] rnd;
    rnd         = '0;
    w_d         = w_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    case (state_q)
      CTRL_IDLE: begin
        if (bus.next) begin
          for (int i = 0; i < 4; i++) w_d[i] = bus.block[127-32*i -: 32];
          keylen_d    = bus.keylen;
          round_ctr_d = 4'd0;
          ready_d     = 1'b0;
        end
      end
      CTRL_INIT: begin
        rnd = cur_blk ^ bus.round_key;
        for (int i = 0; i < 4; i++) w_d[i] = rnd[127-32*i -: 32];
        round_ctr_d = 4'd1;
        sword_ctr_d = 2'd0;
      end
      CTRL_SBOX: begin
        w_d[sword_ctr_q] = sub_word;
        sword_ctr_d      = sword_ctr_q + 2'd1;
      end
      CTRL_MIX: begin
        // Final round omits MixColumns.
        if (is_last) begin
          rnd = shift_rows(cur_blk) ^ bus.round_key;
        end else begin
          rnd         = mix_columns(shift_rows(cur_blk)) ^ bus.round_key;
          round_ctr_d = round_ctr_q + 4'd1;
        end
        for (int i = 0; i < 4; i++) w_d[i] = rnd[127-32*i -: 32];
      end
      CTRL_DONE: ready_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) w_q[i] <= 32'h0;
      round_ctr_q <= 4'd0;
      sword_ctr_q <= 2'd0;
      keylen_q    <= AES_128_BIT_KEY;
      ready_q     <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_aes_encipher_iter.sv
// Directed bench for aes_encipher_iter using FIPS-197 C.1 / C.3 vectors and a
// behavioural key memory built from an independent key expansion.
module tb_aes_encipher_iter;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] JUNK   = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk;
  logic reset;
  logic use_256;
  int   checks;
  int   errors;

  logic [7:0]   sb_tbl [256];
  logic [127:0] rk128 [16];
  logic [127:0] rk256 [16];

  aes_encipher_iter_if bus ();

  aes_encipher_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Key memory: combinational lookup by address.
  assign bus.round_key = use_256 ? rk256[bus.round_key_addr] : rk128[bus.round_key_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] t);
    return {sb_tbl[t[31:24]], sb_tbl[t[23:16]], sb_tbl[t[15:8]], sb_tbl[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_w(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nk == 4) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_addr(input int k, input int nr);
    if (k >= 1 && k <= 5*nr) return 128'(1 + (k-1)/5);
    return '0;
  endfunction

  task automatic accept(input logic [127:0] blk, input logic kl, input logic hold);
    bus.block  = blk;
    bus.keylen = kl;
    bus.next   = 1'b1;
    use_256    = kl;
    @(posedge clk); #1;
    if (!hold) bus.next = 1'b0;
  endtask

  // Called #1 after the accepting edge. Follows the run to ready=1 checking
  // the key address every cycle; optionally pulses next with junk at pa/pb.
  task automatic wait_done(input string tag, input int nr, input int lat,
                           input logic [127:0] exp, input int pa, input int pb);
    int k;
    k = 0;
    chk({tag, " ready_low"}, 128'(bus.ready), 128'(1'b0));
    chk($sformatf("%s addr k=%0d", tag, k), 128'(bus.round_key_addr), exp_addr(k, nr));
    while (bus.ready !== 1'b1 && k < 200) begin
      if (pa >= 0) begin
        if (k == pa || k == pb) begin
          bus.next   = 1'b1;
          bus.block  = JUNK;
          bus.keylen = 1'b1;
        end else begin
          bus.next = 1'b0;
        end
      end
      @(posedge clk); #1;
      k++;
      chk($sformatf("%s addr k=%0d", tag, k), 128'(bus.round_key_addr), exp_addr(k, nr));
    end
    if (pa >= 0) bus.next = 1'b0;
    chk({tag, " latency"}, 128'(k), 128'(lat));
    chk({tag, " result"}, bus.new_block, exp);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    use_256    = 1'b0;
    reset      = 1'b0;
    bus.next   = 1'b0;
    bus.keylen = 1'b0;
    bus.block  = '0;
    sb_tbl = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    for (int i = 0; i < 16; i++) begin
      rk128[i] = '0;
      rk256[i] = '0;
    end
    expand_key(KEY128, 4);
    expand_key(KEY256, 8);

    // Reset state.
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("reset ready", 128'(bus.ready), 128'(1'b1));
    chk("reset new_block", bus.new_block, 128'h0);
    chk("reset addr", 128'(bus.round_key_addr), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle ready", 128'(bus.ready), 128'(1'b1));
    chk("idle new_block", bus.new_block, 128'h0);

    // C.1: AES-128, full address trace.
    accept(PT, 1'b0, 1'b0);
    wait_done("c1", 10, 52, C1_CT, -1, -1);

    // C.3: AES-256.
    accept(PT, 1'b1, 1'b0);
    wait_done("c3", 14, 72, C3_CT, -1, -1);

    // next pulsed with junk while busy must be ignored.
    accept(PT, 1'b0, 1'b0);
    wait_done("busy_next", 10, 52, C1_CT, 10, 30);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_next no_queue ready", 128'(bus.ready), 128'(1'b1));
    chk("busy_next hold", bus.new_block, C1_CT);

    // Reset mid-operation, then restart.
    accept(PT, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst ready", 128'(bus.ready), 128'(1'b1));
    chk("midrst new_block", bus.new_block, 128'h0);
    chk("midrst addr", 128'(bus.round_key_addr), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    accept(PT, 1'b0, 1'b0);
    wait_done("restart", 10, 52, C1_CT, -1, -1);

    // Back-to-back with next held high: C.1 then C.3.
    accept(PT, 1'b0, 1'b1);
    bus.keylen = 1'b1;
    wait_done("b2b first", 10, 52, C1_CT, -1, -1);
    use_256 = 1'b1;
    @(posedge clk); #1;
    wait_done("b2b second", 14, 72, C3_CT, -1, -1);
    bus.next = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b no_dup ready", 128'(bus.ready), 128'(1'b1));
    chk("b2b no_dup result", bus.new_block, C3_CT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
